// File: rtl/ps2_action_decoder.sv
`default_nettype none
// ============================================================================
// Module   : ps2_action_decoder
// Purpose  : PS/2 keyboard receiver and scan-code decoder that drives the
//            5-bit paddle action vector (mAccion) and its qualifying strobe
//            (bandera). Bits are oversampled on the system clock.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_action_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 25000,  // must be >= 2
    parameter int unsigned BANDERA_CYCLES = 4,      // must be >= 1
    parameter logic [7:0]  KEY_START      = 8'h29,
    parameter logic [7:0]  KEY_B1_LEFT    = 8'h1C,
    parameter logic [7:0]  KEY_B1_RIGHT   = 8'h23
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [4:0] mAccion,
    output logic       bandera,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       frame_error
);

    localparam int unsigned     c_TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    // The counter reads (clocks since the last falling edge) - 1; deciding at
    // TIMEOUT_CYCLES-2 makes frame_error visible exactly TIMEOUT_CYCLES
    // clocks after the edge-detect clock.
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 2);
    localparam int unsigned     c_BW       = (BANDERA_CYCLES > 1) ? $clog2(BANDERA_CYCLES) : 1;
    localparam logic [c_BW-1:0] c_B_LOAD   = c_BW'(BANDERA_CYCLES - 1);

    localparam logic [7:0] c_PFX_EXT   = 8'hE0;
    localparam logic [7:0] c_PFX_BRK   = 8'hF0;
    localparam logic [7:0] c_KEY_LARR  = 8'h6B;
    localparam logic [7:0] c_KEY_RARR  = 8'h74;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
        S_PARITY = 2'd2,
        S_STOP   = 2'd3
    } rx_state_t;

    // Synchronisers
    logic r_clk_s1, r_clk_s2, r_clk_prev;
    logic r_dat_s1, r_dat_s2;
    logic w_fe;

    // Receiver
    rx_state_t         r_state;
    logic [2:0]        r_bitcnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [c_TO_W-1:0] r_to_cnt;
    logic [7:0]        r_scan_code;
    logic              r_scan_valid;
    logic              r_frame_error;
    logic              w_timeout;
    logic              w_stop_fe;
    logic              w_frame_ok;
    logic              w_frame_bad;

    // Decoder
    logic       r_ext;
    logic       r_brk;
    logic [4:0] r_maccion;
    logic       r_req;
    logic [4:0] w_key_mask;
    logic       w_key_hit;

    // Strobe generator
    logic            r_band;
    logic [c_BW-1:0] r_bcnt;
    logic            r_pending;
    logic            r_gap;

    // Two-stage synchronisers plus a history stage on the clock line
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fe        = r_clk_prev & ~r_clk_s2;
    // A falling edge in the same clock always beats the timeout.
    assign w_timeout   = (r_state != S_IDLE) && !w_fe && (r_to_cnt == c_TO_LAST);
    assign w_stop_fe   = (r_state == S_STOP) && w_fe;
    assign w_frame_ok  = w_stop_fe && r_dat_s2 && (^{r_shift, r_parity});
    assign w_frame_bad = (w_stop_fe && !w_frame_ok) || w_timeout;

    // Frame receiver: start/data/parity/stop sequencing with inactivity timeout
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state       <= S_IDLE;
            r_bitcnt      <= 3'd0;
            r_shift       <= 8'h00;
            r_parity      <= 1'b0;
            r_to_cnt      <= '0;
            r_scan_code   <= 8'h00;
            r_scan_valid  <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_scan_valid  <= 1'b0;
            r_frame_error <= 1'b0;

            if (w_fe) begin
                r_to_cnt <= '0;
            end else if (r_state != S_IDLE) begin
                r_to_cnt <= r_to_cnt + c_TO_W'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (w_fe) begin
                        if (!r_dat_s2) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= 3'd0;
                        end else begin
                            r_frame_error <= 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_fe) begin
                        r_shift <= {r_dat_s2, r_shift[7:1]};
                        if (r_bitcnt == 3'd7) begin
                            r_state <= S_PARITY;
                        end else begin
                            r_bitcnt <= r_bitcnt + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_fe) begin
                        r_parity <= r_dat_s2;
                        r_state  <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_fe) begin
                        r_state <= S_IDLE;
                        if (w_frame_ok) begin
                            r_scan_code  <= r_shift;
                            r_scan_valid <= 1'b1;
                        end else begin
                            r_frame_error <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_timeout) begin
                r_state       <= S_IDLE;
                r_to_cnt      <= '0;
                r_frame_error <= 1'b1;
            end
        end
    end

    // Map the completed byte to an action bit, honouring the E0 prefix
    always_comb begin
        w_key_mask = 5'b00000;
        if (r_ext) begin
            if (r_shift == c_KEY_LARR) begin
                w_key_mask = 5'b10000;
            end else if (r_shift == c_KEY_RARR) begin
                w_key_mask = 5'b01000;
            end
        end else begin
            if (r_shift == KEY_START) begin
                w_key_mask = 5'b00001;
            end else if (r_shift == KEY_B1_LEFT) begin
                w_key_mask = 5'b00010;
            end else if (r_shift == KEY_B1_RIGHT) begin
                w_key_mask = 5'b00100;
            end
        end
    end

    assign w_key_hit = |w_key_mask;

    // Prefix tracking and action-bit update; results land with scan_valid
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_ext     <= 1'b0;
            r_brk     <= 1'b0;
            r_maccion <= 5'b00000;
            r_req     <= 1'b0;
        end else begin
            r_req <= 1'b0;
            if (w_frame_bad) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_frame_ok) begin
                if (r_shift == c_PFX_EXT) begin
                    r_ext <= 1'b1;
                end else if (r_shift == c_PFX_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (w_key_hit) begin
                        if (r_brk) begin
                            r_maccion <= r_maccion & ~w_key_mask;
                        end else begin
                            r_maccion <= r_maccion | w_key_mask;
                            r_req     <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Strobe generator: fixed-width pulses, one merged pending request,
    // and a single low clock between back-to-back pulses
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_band    <= 1'b0;
            r_bcnt    <= '0;
            r_pending <= 1'b0;
            r_gap     <= 1'b0;
        end else begin
            if (r_band) begin
                if (r_req) begin
                    r_pending <= 1'b1;
                end
                if (r_bcnt == '0) begin
                    r_band <= 1'b0;
                    if (r_pending || r_req) begin
                        r_gap <= 1'b1;
                    end
                end else begin
                    r_bcnt <= r_bcnt - c_BW'(1);
                end
            end else if (r_gap) begin
                r_band    <= 1'b1;
                r_bcnt    <= c_B_LOAD;
                r_gap     <= 1'b0;
                r_pending <= 1'b0;
            end else if (r_req) begin
                r_band <= 1'b1;
                r_bcnt <= c_B_LOAD;
            end
        end
    end

    assign mAccion     = r_maccion;
    assign bandera     = r_band;
    assign scan_code   = r_scan_code;
    assign scan_valid  = r_scan_valid;
    assign frame_error = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_ps2_action_decoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_action_decoder
// Purpose  : Directed scoreboard bench for ps2_action_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_action_decoder;

    localparam int c_HP      = 20;     // PS/2 half period, system clocks
    localparam int c_HP_FAST = 2;      // compressed PS/2 half period
    localparam int c_TIMEOUT = 25000;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2_clk_a, ps2_data_a, ps2_clk_b, ps2_data_b;
    logic [4:0] macc_a, macc_b;
    logic       band_a, band_b;
    logic [7:0] code_a, code_b;
    logic       sv_a, sv_b, ferr_a, ferr_b;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;

    always #20 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    ps2_action_decoder dut_a (
        .Clock       (clk),
        .Reset       (rst),
        .ps2_clk     (ps2_clk_a),
        .ps2_data    (ps2_data_a),
        .mAccion     (macc_a),
        .bandera     (band_a),
        .scan_code   (code_a),
        .scan_valid  (sv_a),
        .frame_error (ferr_a)
    );

    ps2_action_decoder #(.BANDERA_CYCLES(64)) dut_b (
        .Clock       (clk),
        .Reset       (rst),
        .ps2_clk     (ps2_clk_b),
        .ps2_data    (ps2_data_b),
        .mAccion     (macc_b),
        .bandera     (band_b),
        .scan_code   (code_b),
        .scan_valid  (sv_b),
        .frame_error (ferr_b)
    );

    // Observation side of instance A: scan_valid capture, error and strobe timing
    logic [12:0] a_obs[$];
    int   a_sv_cnt = 0, a_fe_cnt = 0, a_fe_cyc = 0;
    int   a_rise_cnt = 0, a_rise_cyc = 0, a_fall_cyc = 0, a_width = 0;
    logic a_band_prev = 1'b0;
    always @(negedge clk) begin
        if (sv_a) begin
            a_obs.push_back({macc_a, code_a});
            a_sv_cnt++;
        end
        if (ferr_a) begin
            a_fe_cnt++;
            a_fe_cyc = cyc;
        end
        if (band_a && !a_band_prev) begin
            a_rise_cnt++;
            a_rise_cyc = cyc;
        end
        if (!band_a && a_band_prev) begin
            a_fall_cyc = cyc;
            a_width    = cyc - a_rise_cyc;
        end
        a_band_prev = band_a;
    end

    // Observation side of instance B: strobe widths and spacing
    int   b_sv_cnt = 0, b_rise_cnt = 0, b_rise_cyc = 0, b_first_rise = -1;
    int   b_fall_cyc = 0, b_gap = 0, b_w_prev = 0, b_w_last = 0;
    logic b_band_prev = 1'b0;
    always @(negedge clk) begin
        if (sv_b) b_sv_cnt++;
        if (band_b && !b_band_prev) begin
            if (b_rise_cnt == 0) b_first_rise = cyc;
            b_rise_cnt++;
            b_gap      = cyc - b_fall_cyc;
            b_rise_cyc = cyc;
        end
        if (!band_b && b_band_prev) begin
            b_fall_cyc = cyc;
            b_w_prev   = b_w_last;
            b_w_last   = cyc - b_rise_cyc;
        end
        b_band_prev = band_b;
    end

    logic [12:0] exp_q[$];
    int          rd_ptr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pop every expected {mAccion, scan_code} and match it to the captured output
    task automatic sb_check(input string tag);
        logic [12:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_ptr < a_obs.size()) begin
                chk(tag, 32'(a_obs[rd_ptr]), 32'(e));
                rd_ptr++;
            end else begin
                chk({tag, "_count"}, 32'(a_obs.size()), 32'(rd_ptr + 1));
            end
        end
        chk({tag, "_extra"}, 32'(a_obs.size()), 32'(rd_ptr));
        rd_ptr = a_obs.size();
    endtask

    // Drive the first n bits of an 11-bit frame; returns the cycle of the last falling edge
    task automatic send_bits(input bit sel, input logic [7:0] b, input bit bad_par,
                             input int n, input int hp, output int last_fall);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        last_fall = 0;
        for (int i = 0; i < n; i++) begin
            if (sel) ps2_data_b = fr[i]; else ps2_data_a = fr[i];
            repeat (hp) @(negedge clk);
            if (sel) ps2_clk_b = 1'b0; else ps2_clk_a = 1'b0;
            last_fall = cyc;
            repeat (hp) @(negedge clk);
            if (sel) ps2_clk_b = 1'b1; else ps2_clk_a = 1'b1;
        end
        if (sel) ps2_data_b = 1'b1; else ps2_data_a = 1'b1;
    endtask

    task automatic send_a(input logic [7:0] b, input bit bad_par, output int last_fall);
        send_bits(1'b0, b, bad_par, 11, c_HP, last_fall);
        repeat (10) @(negedge clk);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int lf, lf1, s_sv, s_fe, s_rise;
        rst = 1'b1;
        ps2_clk_a = 1'b1; ps2_data_a = 1'b1;
        ps2_clk_b = 1'b1; ps2_data_b = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_maccion",  32'(macc_a), 32'h0);
        chk("rst_bandera",  32'(band_a), 32'h0);
        chk("rst_scan",     32'(code_a), 32'h0);
        chk("rst_valid",    32'(sv_a),   32'h0);
        chk("rst_ferr",     32'(ferr_a), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a frame, then a clean 1C
        s_fe = a_fe_cnt; s_rise = a_rise_cnt; s_sv = a_sv_cnt;
        send_bits(1'b0, 8'h1C, 1'b0, 5, c_HP, lf);
        repeat (5) @(negedge clk);
        pulse_reset();
        exp_q.push_back({5'b00010, 8'h1C});
        send_a(8'h1C, 1'b0, lf);
        repeat (10) @(negedge clk);
        sb_check("t1_sb");
        chk("t1_scan",       32'(code_a), 32'h1C);
        chk("t1_maccion",    32'(macc_a), 32'h02);
        chk("t1_valid_cnt",  32'(a_sv_cnt - s_sv), 32'd1);
        chk("t1_pulses",     32'(a_rise_cnt - s_rise), 32'd1);
        chk("t1_width",      32'(a_width), 32'd4);
        chk("t1_rise_cycle", 32'(a_rise_cyc), 32'(lf + 4));
        chk("t1_ferr",       32'(a_fe_cnt - s_fe), 32'd0);

        // Press and release A
        pulse_reset();
        s_sv = a_sv_cnt; s_rise = a_rise_cnt;
        exp_q.push_back({5'b00010, 8'h1C}); send_a(8'h1C, 1'b0, lf);
        exp_q.push_back({5'b00010, 8'hF0}); send_a(8'hF0, 1'b0, lf);
        exp_q.push_back({5'b00000, 8'h1C}); send_a(8'h1C, 1'b0, lf);
        sb_check("t2_sb");
        chk("t2_valid_cnt", 32'(a_sv_cnt - s_sv), 32'd3);
        chk("t2_pulses",    32'(a_rise_cnt - s_rise), 32'd1);
        chk("t2_maccion",   32'(macc_a), 32'h00);

        // Extended right arrow, then the keypad code
        pulse_reset();
        s_rise = a_rise_cnt;
        exp_q.push_back({5'b00000, 8'hE0}); send_a(8'hE0, 1'b0, lf);
        exp_q.push_back({5'b01000, 8'h74}); send_a(8'h74, 1'b0, lf);
        sb_check("t3_sb_ext");
        chk("t3_pulses_ext", 32'(a_rise_cnt - s_rise), 32'd1);
        s_rise = a_rise_cnt;
        exp_q.push_back({5'b01000, 8'h74}); send_a(8'h74, 1'b0, lf);
        sb_check("t3_sb_kp");
        chk("t3_pulses_kp", 32'(a_rise_cnt - s_rise), 32'd0);
        chk("t3_maccion",   32'(macc_a), 32'h08);

        // Parity errors, and the break prefix discarded by one
        pulse_reset();
        s_sv = a_sv_cnt; s_fe = a_fe_cnt; s_rise = a_rise_cnt;
        send_a(8'h23, 1'b1, lf);
        chk("t4_ferr1",    32'(a_fe_cnt - s_fe), 32'd1);
        chk("t4_novalid",  32'(a_sv_cnt - s_sv), 32'd0);
        chk("t4_maccion1", 32'(macc_a), 32'h00);
        exp_q.push_back({5'b00000, 8'hF0}); send_a(8'hF0, 1'b0, lf);
        send_a(8'h23, 1'b1, lf);
        exp_q.push_back({5'b00100, 8'h23}); send_a(8'h23, 1'b0, lf);
        sb_check("t4_sb");
        chk("t4_ferr2",    32'(a_fe_cnt - s_fe), 32'd2);
        chk("t4_pulses",   32'(a_rise_cnt - s_rise), 32'd1);
        chk("t4_maccion2", 32'(macc_a), 32'h04);

        // Timeout after a partial frame
        pulse_reset();
        s_fe = a_fe_cnt; s_rise = a_rise_cnt;
        send_bits(1'b0, 8'h29, 1'b0, 4, c_HP, lf);
        for (int k = 0; k < c_TIMEOUT + 200 && a_fe_cnt == s_fe; k++) @(negedge clk);
        @(negedge clk);
        chk("t5_ferr_cnt",   32'(a_fe_cnt - s_fe), 32'd1);
        chk("t5_ferr_cycle", 32'(a_fe_cyc), 32'(lf + 2 + c_TIMEOUT));
        exp_q.push_back({5'b00001, 8'h29}); send_a(8'h29, 1'b0, lf);
        sb_check("t5_sb");
        chk("t5_pulses",    32'(a_rise_cnt - s_rise), 32'd1);
        chk("t5_ferr_after", 32'(a_fe_cnt - s_fe), 32'd1);
        chk("t5_maccion",   32'(macc_a), 32'h01);

        // Back-to-back presses on the long-pulse instance
        send_bits(1'b1, 8'h29, 1'b0, 11, c_HP_FAST, lf1);
        send_bits(1'b1, 8'h29, 1'b0, 11, c_HP_FAST, lf);
        repeat (200) @(negedge clk);
        chk("t6_valid_cnt",  32'(b_sv_cnt), 32'd2);
        chk("t6_pulses",     32'(b_rise_cnt), 32'd2);
        chk("t6_first_rise", 32'(b_first_rise), 32'(lf1 + 4));
        chk("t6_width1",     32'(b_w_prev), 32'd64);
        chk("t6_width2",     32'(b_w_last), 32'd64);
        chk("t6_gap",        32'(b_gap), 32'd1);
        chk("t6_maccion",    32'(macc_b), 32'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
